// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: machine word size,
// instruction size, the buffered fetch record, and small PC helpers.
package fetch_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   // One fetched instruction together with the byte address it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   // Redirect targets are forced onto an instruction boundary.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

   // Sequential successor; wraps naturally at the top of the address space.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INST_BYTES);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order buffer between instruction fetch and decode.
// DEPTH must be a power of two (pointers wrap by overflow) and at least 2.
// The head view is forced to zero whenever the buffer is empty so that
// downstream never sees a stale instruction.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           do_push;
   logic           do_pop;

   // A flush wins over everything; a push into a full buffer is only legal
   // when the head leaves in the same cycle, which frees the slot it writes.
   assign do_push = push && !flush && (!full || pop);
   assign do_pop  = pop && !flush && !empty;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign head  = empty ? '0 : mem[rd_ptr];

   // Entry storage: written at the tail on every accepted push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy; a flush empties the buffer and rewinds both pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, reads one instruction
// word per cycle from a combinational instruction memory and queues it,
// tagged with its address, in a small FIFO towards decode. A taken branch
// redirects the PC and throws away everything fetched down the old path.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc
);

   logic [XLEN-1:0] pc;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   fetch_entry_t    wentry;
   fetch_entry_t    head;

   // Fetch whenever there is room (or room is being made by a pop) and we
   // are not being redirected; a redirect squashes the word on imem this cycle.
   assign pop    = out_valid && out_ready;
   assign push   = !br_taken && (!full || pop);
   assign wentry = '{pc: pc, inst: imem_inst};

   // Program counter: redirect, advance on fetch, otherwise stall in place.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (br_taken) begin
         pc <= align_pc(br_target);
      end else if (push) begin
         pc <= next_pc(pc);
      end
   end

   assign imem_addr = pc;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (br_taken),
      .wdata (wentry),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   assign out_valid = !empty;
   assign out_inst  = head.inst;
   assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and scoreboard bench for the fetch stage. A second instance with
// a reset PC near the top of the address space checks PC wrap-around.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        br_taken;
   logic [31:0] br_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   logic [31:0] wrap_addr;
   logic [31:0] wrap_imem;
   logic        wrap_valid;
   logic [31:0] wrap_inst;
   logic [31:0] wrap_pc;
   logic        wrap_br;
   logic [31:0] wrap_target;
   logic        wrap_ready;

   int errors = 0;
   int checks = 0;

   // Instruction memory image; words 0 and 1 are fixed, the rest are unique per address.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      case (addr[31:2])
         30'd0:   memWord = 32'h0022_0000;
         30'd1:   memWord = 32'h0064_0000;
         default: memWord = {addr[31:2], 2'b11} ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign imem_inst = memWord(imem_addr);
   assign wrap_imem = memWord(wrap_addr);

   assign wrap_br     = 1'b0;
   assign wrap_target = 32'h0;
   assign wrap_ready  = 1'b1;

   fetch_unit dut (
      .clk       (clk),
      .rst       (rst),
      .imem_addr (imem_addr),
      .imem_inst (imem_inst),
      .br_taken  (br_taken),
      .br_target (br_target),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_pc    (out_pc)
   );

   fetch_unit #(
      .RESET_PC (32'hFFFF_FFF8),
      .DEPTH    (2)
   ) dut_wrap (
      .clk       (clk),
      .rst       (rst),
      .imem_addr (wrap_addr),
      .imem_inst (wrap_imem),
      .br_taken  (wrap_br),
      .br_target (wrap_target),
      .out_valid (wrap_valid),
      .out_ready (wrap_ready),
      .out_inst  (wrap_inst),
      .out_pc    (wrap_pc)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        br;
      logic [31:0] target;
      logic        ready;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] addr;
   } vec_t;

   vec_t        vecs [10];
   logic [31:0] wrapExp [3];

   task automatic applyStimulus(input logic b, input logic [31:0] t, input logic r);
      br_taken  = b;
      br_target = t;
      out_ready = r;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Pulse reset over a rising edge and release it at a falling edge.
   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] expPc;
      int          delivered;
      logic        b;
      logic [31:0] t;
      logic        r;

      vecs[0] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  memWord(32'h0),  32'h4};
      vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  memWord(32'h4),  32'h8};
      vecs[2] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  memWord(32'h4),  32'hC};
      vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  memWord(32'h4),  32'hC};
      vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  memWord(32'h8),  32'h10};
      vecs[5] = '{1'b1, 32'h13, 1'b1, 1'b0, 32'h0,  32'h0,           32'h10};
      vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, memWord(32'h10), 32'h14};
      vecs[7] = '{1'b1, 32'h2,  1'b0, 1'b0, 32'h0,  32'h0,           32'h0};
      vecs[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  memWord(32'h0),  32'h4};
      vecs[9] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  memWord(32'h4),  32'h8};

      wrapExp[0] = 32'hFFFF_FFF8;
      wrapExp[1] = 32'hFFFF_FFFC;
      wrapExp[2] = 32'h0000_0000;

      // Asynchronous reset before any clock edge has occurred.
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0);
      #2 rst = 1'b0;
      #1;
      checkOutput("reset valid", {31'b0, out_valid}, 32'h0);
      checkOutput("reset pc", out_pc, 32'h0);
      checkOutput("reset inst", out_inst, 32'h0);
      checkOutput("reset imem_addr", imem_addr, 32'h0);
      checkOutput("reset wrap imem_addr", wrap_addr, 32'hFFFF_FFF8);

      // Release at a falling edge; every table step starts at a falling edge.
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].br, vecs[i].target, vecs[i].ready);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d valid", i), {31'b0, out_valid}, {31'b0, vecs[i].valid});
         checkOutput($sformatf("vec%0d pc", i), out_pc, vecs[i].pc);
         checkOutput($sformatf("vec%0d inst", i), out_inst, vecs[i].inst);
         checkOutput($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].addr);
         if (i < 3) begin
            checkOutput($sformatf("wrap%0d pc", i), wrap_pc, wrapExp[i]);
            checkOutput($sformatf("wrap%0d inst", i), wrap_inst, memWord(wrapExp[i]));
         end
         @(negedge clk);
      end

      // Downstream stalled: buffer fills to two and the PC stalls at 8.
      doReset();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("stall%0d pc", k), out_pc, 32'h0);
         checkOutput($sformatf("stall%0d imem_addr", k), imem_addr, (k == 0) ? 32'h4 : 32'h8);
         @(negedge clk);
      end
      // Drain: 0, 4, 8 handed over on consecutive edges.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b1);
         checkOutput($sformatf("drain%0d valid", k), {31'b0, out_valid}, 32'h1);
         checkOutput($sformatf("drain%0d pc", k), out_pc, 32'(k * 4));
         @(posedge clk);
         @(negedge clk);
      end

      // Reset mid-cycle with a full buffer: outputs clear without a clock edge.
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("async valid", {31'b0, out_valid}, 32'h0);
      checkOutput("async imem_addr", imem_addr, 32'h0);
      checkOutput("async pc", out_pc, 32'h0);
      checkOutput("async inst", out_inst, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("restart pc", out_pc, 32'h0);
      checkOutput("restart inst", out_inst, memWord(32'h0));
      @(negedge clk);

      // Random scoreboard: every accepted instruction must follow the
      // sequential/redirected address stream and match memory.
      doReset();
      expPc     = 32'h0;
      delivered = 0;
      for (int c = 0; c < 10000; c++) begin
         b = ($urandom_range(0, 19) == 0);
         t = $urandom;
         r = ($urandom_range(0, 3) != 0);
         applyStimulus(b, t, r);
         if (!out_valid) begin
            checkOutput("sb idle zero", out_pc | out_inst, 32'h0);
         end
         if (b) begin
            expPc = {t[31:2], 2'b00};
         end else if (out_valid && r) begin
            checkOutput("sb pc", out_pc, expPc);
            checkOutput("sb inst", out_inst, memWord(expPc));
            expPc = expPc + 32'd4;
            delivered++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("sb enough deliveries", {31'b0, delivered > 4000}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
